// File: rtl/prach_hb_dec_tdm.sv
// Half-band decimate-by-2 FIR for a channel-interleaved PRACH stream.
// Even rounds feed the odd-tap line; odd rounds feed the centre line and emit one sample per channel.
module prach_hb_dec_tdm #(
  parameter int NUM_CH  = 16,
  parameter int DW      = 16,
  parameter int CW      = 18,
  parameter int NUM_COE = 2,
  parameter int COE [NUM_COE] = '{-4134, 36901}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din_dq,
  input  logic                 din_dv,
  input  logic [7:0]           din_chn,
  input  logic                 sync_in,
  input  logic                 bypass,
  output logic signed [DW-1:0] dout_dq,
  output logic                 dout_dv,
  output logic [7:0]           dout_chn,
  output logic                 sync_out,
  output logic                 ovf,
  output logic                 ord_err
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LG  = $clog2(NUM_COE);
  localparam int NP  = 1 << LG;
  localparam int NT  = 2 * NUM_COE;
  localparam int LAT = 5 + LG;
  localparam int PW  = DW + 1;
  localparam int AW  = PW + CW + LG + 2;
  localparam logic signed [AW-1:0] RND  = AW'(1) <<< (CW - 2);
  localparam logic signed [AW-1:0] YMAX = (AW'(1) <<< (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  typedef struct packed {
    logic          vld;
    logic          odd;
    logic          byp;
    logic          sync;
    logic [7:0]    chn;
    logic [DW-1:0] raw;
  } side_t;

  logic                 r_odd, r_byp, r_sync_pend;
  logic [CHW-1:0]       r_exp;
  logic signed [DW-1:0] r_x2 [NUM_CH][NT];
  logic signed [DW-1:0] r_x1 [NUM_CH][NUM_COE];
  logic signed [DW-1:0] r_tap [NT];
  logic signed [DW-1:0] r_ctr0, r_ctr1;
  logic signed [PW-1:0] r_pre [NUM_COE];
  logic signed [AW-1:0] r_node [2*NP-1];
  logic signed [AW-1:0] r_cpipe [LG+1];
  logic signed [AW-1:0] r_acc, r_y;
  side_t                r_side [LAT];

  logic [CHW-1:0]       w_ch;
  logic                 w_odd, w_byp, w_last, w_err, w_sync;
  logic signed [DW-1:0] w_x2n [NT];
  logic signed [DW-1:0] w_x1n [NUM_COE];

  // A sync sample always restarts in the even round with the freshly sampled bypass mode.
  assign w_ch   = din_chn[CHW-1:0];
  assign w_odd  = r_odd & ~sync_in;
  assign w_byp  = sync_in ? bypass : r_byp;
  assign w_last = (din_chn == 8'(NUM_CH - 1));
  assign w_err  = ~sync_in && (din_chn != 8'(r_exp));
  assign w_sync = w_byp ? sync_in : (w_odd & r_sync_pend);

  always_comb begin
    for (int k = 0; k < NT; k++) w_x2n[k] = r_x2[w_ch][k];
    for (int k = 0; k < NUM_COE; k++) w_x1n[k] = r_x1[w_ch][k];
    if (!w_odd) begin
      w_x2n[0] = din_dq;
      for (int k = 1; k < NT; k++) w_x2n[k] = r_x2[w_ch][k-1];
    end else begin
      w_x1n[0] = din_dq;
      for (int k = 1; k < NUM_COE; k++) w_x1n[k] = r_x1[w_ch][k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_odd       <= 1'b0;
      r_byp       <= 1'b0;
      r_sync_pend <= 1'b0;
      r_exp       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NT; k++) r_x2[c][k] <= '0;
        for (int k = 0; k < NUM_COE; k++) r_x1[c][k] <= '0;
      end
      for (int k = 0; k < NT; k++) r_tap[k] <= '0;
      r_ctr0 <= '0;
      r_ctr1 <= '0;
      for (int k = 0; k < NUM_COE; k++) r_pre[k] <= '0;
      for (int i = 0; i < 2*NP-1; i++) r_node[i] <= '0;
      for (int j = 0; j <= LG; j++) r_cpipe[j] <= '0;
      r_acc <= '0;
      r_y   <= '0;
      for (int j = 0; j < LAT; j++) r_side[j] <= '0;
      dout_dq  <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      sync_out <= 1'b0;
      ovf      <= 1'b0;
      ord_err  <= 1'b0;
    end else begin
      ord_err <= din_dv & w_err;
      if (din_dv) begin
        r_odd       <= w_last ? ~w_odd : w_odd;
        r_exp       <= w_ch + 1'b1;
        r_sync_pend <= ~w_byp & (sync_in | (r_sync_pend & ~w_odd));
        if (sync_in) r_byp <= bypass;
        for (int k = 0; k < NT; k++) r_x2[w_ch][k] <= w_x2n[k];
        for (int k = 0; k < NUM_COE; k++) r_x1[w_ch][k] <= w_x1n[k];
      end

      // Taps are captured from the post-update lines so back-to-back same-channel samples are safe.
      for (int k = 0; k < NT; k++) r_tap[k] <= w_x2n[k];
      r_ctr0    <= w_x1n[NUM_COE-1];
      r_side[0] <= '{vld: din_dv, odd: w_odd, byp: w_byp, sync: w_sync, chn: din_chn, raw: din_dq};
      for (int j = 1; j < LAT; j++) r_side[j] <= r_side[j-1];

      for (int k = 0; k < NUM_COE; k++) r_pre[k] <= PW'(r_tap[k]) + PW'(r_tap[NT-1-k]);
      r_ctr1 <= r_ctr0;

      for (int k = 0; k < NUM_COE; k++) r_node[NP-1+k] <= AW'(r_pre[k]) * AW'(COE[k]);
      for (int k = NUM_COE; k < NP; k++) r_node[NP-1+k] <= '0;
      for (int i = 0; i < NP - 1; i++) r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
      r_cpipe[0] <= AW'(r_ctr1) <<< (CW - 2);
      for (int j = 1; j <= LG; j++) r_cpipe[j] <= r_cpipe[j-1];

      r_acc <= r_node[0] + r_cpipe[LG];
      r_y   <= (r_acc + RND) >>> (CW - 1);

      dout_chn <= r_side[LAT-1].chn;
      sync_out <= r_side[LAT-1].vld & r_side[LAT-1].sync;
      ovf      <= 1'b0;
      if (r_side[LAT-1].byp) begin
        dout_dv <= r_side[LAT-1].vld;
        dout_dq <= r_side[LAT-1].raw;
      end else begin
        dout_dv <= r_side[LAT-1].vld & r_side[LAT-1].odd;
        if (r_y > YMAX) begin
          dout_dq <= YMAX[DW-1:0];
          ovf     <= r_side[LAT-1].vld & r_side[LAT-1].odd;
        end else if (r_y < YMIN) begin
          dout_dq <= YMIN[DW-1:0];
          ovf     <= r_side[LAT-1].vld & r_side[LAT-1].odd;
        end else begin
          dout_dq <= r_y[DW-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_prach_hb_dec_tdm.sv
// Directed self-checking bench for prach_hb_dec_tdm with the default K=2 coefficient set.
module tb_prach_hb_dec_tdm;
  localparam int NCH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] din_dq = '0;
  logic din_dv = 1'b0;
  logic [7:0] din_chn = '0;
  logic sync_in = 1'b0;
  logic bypass = 1'b0;
  logic signed [15:0] dout_dq;
  logic dout_dv;
  logic [7:0] dout_chn;
  logic sync_out, ovf, ord_err;

  int n_chk = 0;
  int n_fail = 0;

  prach_hb_dec_tdm dut (
    .clk(clk), .rst_n(rst_n), .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn),
    .sync_in(sync_in), .bypass(bypass), .dout_dq(dout_dq), .dout_dv(dout_dv),
    .dout_chn(dout_chn), .sync_out(sync_out), .ovf(ovf), .ord_err(ord_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int oq [NCH][$];
  int fq [NCH][$];
  int n_out, n_sync, sync_idx, first_cyc, n_err, err_cyc, acc_cyc;
  int stim [24][NCH];

  always @(negedge clk) begin
    if (dout_dv === 1'b1) begin
      if (first_cyc < 0) first_cyc = cyc;
      if (sync_out === 1'b1) begin n_sync++; sync_idx = n_out; end
      oq[int'(dout_chn[3:0])].push_back(int'(dout_dq));
      fq[int'(dout_chn[3:0])].push_back(int'(ovf));
      n_out++;
    end
    if (ord_err === 1'b1) begin n_err++; err_cyc = cyc; end
  end

  task automatic send(input int ch, input int v, input bit s);
    @(negedge clk);
    din_dv = 1'b1; din_chn = 8'(ch); din_dq = 16'(v); sync_in = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_dv = 1'b0; sync_in = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_dv = 1'b0; sync_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_mon();
    #1;
    for (int c = 0; c < NCH; c++) begin oq[c].delete(); fq[c].delete(); end
    n_out = 0; n_sync = 0; sync_idx = -1; first_cyc = -1; n_err = 0; err_cyc = -1;
  endtask

  task automatic run_rounds(input int nr, input int gapmax, input bit sync0);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < NCH; c++) begin
        send(c, stim[r][c], sync0 && r == 0 && c == 0);
        if (r == 1 && c == 0) acc_cyc = cyc + 1;
        if (gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
      end
    idle(12);
  endtask

  function automatic int qget(input int ch, input int i);
    return (i < oq[ch].size()) ? oq[ch][i] : -99999;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (dout_dq !== 16'sd0) begin n_fail++; $display("FAIL reset_dq: got %0d want 0", dout_dq); end
    n_chk++; if (dout_dv !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dout_dv); end
    n_chk++; if (dout_chn !== 8'd0) begin n_fail++; $display("FAIL reset_chn: got %0d want 0", dout_chn); end
    n_chk++; if (sync_out !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", sync_out); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_chk++; if (ord_err !== 1'b0) begin n_fail++; $display("FAIL reset_ord_err: got %b want 0", ord_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_impulse(input bit odd_r, input int gapmax, input bit rst_first, input string nm);
    int exp_v [6];
    int bad;
    if (odd_r) exp_v = '{0, 8192, 0, 0, 0, 0};
    else       exp_v = '{-517, 4613, 4613, -517, 0, 0};
    foreach (stim[r, c]) stim[r][c] = 0;
    stim[odd_r ? 1 : 0][3] = 16384;
    if (rst_first) do_reset();
    clear_mon();
    run_rounds(12, gapmax, 1'b0);
    n_chk++;
    if (n_out !== 6 * NCH) begin n_fail++; $display("FAIL %s_count: got %0d want %0d", nm, n_out, 6 * NCH); end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (qget(3, i) !== exp_v[i]) begin
        n_fail++; $display("FAIL %s_ch3[%0d]: got %0d want %0d", nm, i, qget(3, i), exp_v[i]);
      end
    end
    bad = 0;
    for (int c = 0; c < NCH; c++)
      if (c != 3) foreach (oq[c][i]) if (oq[c][i] != 0) bad++;
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL %s_other_ch: got %0d nonzero want 0", nm, bad); end
  endtask

  task automatic test_dc();
    foreach (stim[r, c]) stim[r][c] = 1000;
    do_reset();
    clear_mon();
    run_rounds(20, 0, 1'b0);
    n_chk++; if (n_out !== 10 * NCH) begin n_fail++; $display("FAIL dc_count: got %0d want %0d", n_out, 10 * NCH); end
    n_chk++; if (first_cyc - acc_cyc !== 6) begin n_fail++; $display("FAIL dc_latency: got %0d want 6", first_cyc - acc_cyc); end
    for (int c = 0; c < NCH; c++) begin
      int bad;
      bad = 0;
      for (int i = 3; i < 10; i++) if (qget(c, i) != 1000) bad++;
      n_chk++;
      if (bad !== 0) begin n_fail++; $display("FAIL dc_steady_ch%0d: got %0d wrong want 0 (e.g. %0d vs 1000)", c, bad, qget(c, 9)); end
    end
  endtask

  task automatic test_sat();
    int ev [4] = '{-32768, 32767, 32767, -32768};
    int ov [4] = '{0, 0, 32767, 32767};
    int exp_v [4] = '{1034, -10259, -1034, 32767};
    int exp_f [4] = '{0, 0, 0, 1};
    foreach (stim[r, c]) stim[r][c] = 0;
    for (int p = 0; p < 4; p++) begin stim[2*p][0] = ev[p]; stim[2*p+1][0] = ov[p]; end
    do_reset();
    clear_mon();
    run_rounds(8, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int f;
      f = (i < fq[0].size()) ? fq[0][i] : -1;
      n_chk++;
      if (qget(0, i) !== exp_v[i]) begin n_fail++; $display("FAIL sat_val[%0d]: got %0d want %0d", i, qget(0, i), exp_v[i]); end
      n_chk++;
      if (f !== exp_f[i]) begin n_fail++; $display("FAIL sat_ovf[%0d]: got %0d want %0d", i, f, exp_f[i]); end
    end
  endtask

  task automatic test_bypass_sync();
    int t0, bad, badf;
    do_reset();
    @(negedge clk);
    bypass = 1'b1;
    clear_mon();
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      send(i % NCH, 100 + 37 * i - (i % 2) * 5000, i == 0);
      if (i == 0) t0 = cyc + 1;
    end
    idle(12);
    n_chk++; if (n_out !== 20) begin n_fail++; $display("FAIL byp_count: got %0d want 20", n_out); end
    n_chk++; if (first_cyc - t0 !== 6) begin n_fail++; $display("FAIL byp_latency: got %0d want 6", first_cyc - t0); end
    n_chk++; if (n_sync !== 1 || sync_idx !== 0) begin n_fail++; $display("FAIL byp_sync: got n=%0d idx=%0d want n=1 idx=0", n_sync, sync_idx); end
    bad = 0;
    for (int i = 0; i < 20; i++) if (qget(i % NCH, i / NCH) != 100 + 37 * i - (i % 2) * 5000) bad++;
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL byp_echo: got %0d wrong want 0", bad); end
    badf = 0;
    for (int c = 0; c < NCH; c++) foreach (fq[c][i]) if (fq[c][i] != 0) badf++;
    n_chk++; if (badf !== 0) begin n_fail++; $display("FAIL byp_ovf: got %0d set want 0", badf); end
    bypass = 1'b0;
    clear_mon();
    foreach (stim[r, c]) stim[r][c] = 500;
    run_rounds(4, 0, 1'b1);
    n_chk++; if (n_out !== 2 * NCH) begin n_fail++; $display("FAIL resume_count: got %0d want %0d", n_out, 2 * NCH); end
    n_chk++; if (n_sync !== 1 || sync_idx !== 0) begin n_fail++; $display("FAIL resume_sync: got n=%0d idx=%0d want n=1 idx=0", n_sync, sync_idx); end
  endtask

  task automatic test_order_gaps();
    int seq [5] = '{0, 1, 2, 5, 6};
    int t5;
    do_reset();
    clear_mon();
    t5 = 0;
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 10 * i, 1'b0);
      if (seq[i] == 5) t5 = cyc + 1;
      idle(int'($urandom_range(3, 1)));
    end
    for (int c = 7; c < NCH; c++) begin
      send(c, 0, 1'b0);
      idle(int'($urandom_range(2, 0)));
    end
    send(0, 0, 1'b0);
    idle(4);
    n_chk++; if (n_err !== 1) begin n_fail++; $display("FAIL ord_count: got %0d want 1", n_err); end
    n_chk++; if (err_cyc !== t5) begin n_fail++; $display("FAIL ord_cycle: got %0d want %0d", err_cyc, t5); end
  endtask

  task automatic test_reset_mid();
    bit stop;
    foreach (stim[r, c]) stim[r][c] = 1000;
    do_reset();
    stop = 1'b0;
    for (int r = 0; r < 4 && !stop; r++)
      for (int c = 0; c < NCH && !stop; c++) begin
        send(c, stim[r][c], 1'b0);
        if (r == 3 && c == 9) stop = 1'b1;
      end
    do_reset();
    clear_mon();
    idle(12);
    n_chk++; if (n_out !== 0) begin n_fail++; $display("FAIL midreset_flush: got %0d outputs want 0", n_out); end
    test_impulse(1'b0, 0, 1'b0, "impulse_after_reset");
  endtask

  initial begin
    test_reset();
    test_impulse(1'b0, 0, 1'b1, "impulse_even");
    test_impulse(1'b1, 0, 1'b1, "impulse_odd");
    test_dc();
    test_sat();
    test_bypass_sync();
    test_order_gaps();
    test_impulse(1'b0, 3, 1'b1, "impulse_gaps");
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
